// File: rtl/render_cmd_master_pkg.sv
// Shared definitions for the renderer command master: register map, packed
// command format, FSM state type and per-state write helpers.
package render_pkg;

  localparam logic [3:0] REG_X    = 4'd1;
  localparam logic [3:0] REG_Y    = 4'd2;
  localparam logic [3:0] REG_NEG  = 4'd3;
  localparam logic [3:0] REG_TEX  = 4'd4;
  localparam logic [3:0] REG_PLOT = 4'd6;

  typedef struct packed {
    logic [7:0] tex;
    logic [8:0] x;
    logic [7:0] y;
    logic       neg_x;
    logic       neg_y;
    logic       coords;
  } render_cmd_t;

  localparam int unsigned CMD_W = $bits(render_cmd_t);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TEX,
    ST_NEGX,
    ST_X,
    ST_NEGY,
    ST_Y,
    ST_NEGCLR,
    ST_PLOT
  } render_state_t;

  // Successor of an accepted write state; PLOT is handled by the caller since
  // it depends on queue occupancy.
  function automatic render_state_t next_write_state(render_state_t s, render_cmd_t c);
    render_state_t n;
    n = ST_IDLE;
    case (s)
      ST_TEX:    n = c.coords ? ST_NEGX : ST_PLOT;
      ST_NEGX:   n = ST_X;
      ST_X:      n = (c.neg_y != c.neg_x) ? ST_NEGY : ST_Y;
      ST_NEGY:   n = ST_Y;
      ST_Y:      n = c.neg_y ? ST_NEGCLR : ST_PLOT;
      ST_NEGCLR: n = ST_PLOT;
      default:   n = ST_IDLE;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] state_addr(render_state_t s);
    logic [3:0] a;
    a = '0;
    case (s)
      ST_TEX:                       a = REG_TEX;
      ST_NEGX, ST_NEGY, ST_NEGCLR:  a = REG_NEG;
      ST_X:                         a = REG_X;
      ST_Y:                         a = REG_Y;
      ST_PLOT:                      a = REG_PLOT;
      default:                      a = '0;
    endcase
    return a;
  endfunction

  function automatic logic [31:0] state_data(render_state_t s, render_cmd_t c);
    logic [31:0] d;
    d = '0;
    case (s)
      ST_TEX:  d = {24'd0, c.tex};
      ST_NEGX: d = {31'd0, c.neg_x};
      ST_X:    d = {23'd0, c.x};
      ST_NEGY: d = {31'd0, c.neg_y};
      ST_Y:    d = {24'd0, c.y};
      ST_PLOT: d = 32'd1;
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/render_cmd_fifo.sv
// Synchronous FIFO with occupancy count; pushes while full and pops while
// empty are ignored.
module render_cmd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 28
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/render_cmd_master.sv
// Avalon-MM write master that expands queued draw commands into the renderer's
// register write sequence, honouring waitrequest on every write.
module render_cmd_master
  import render_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [7:0]                  cmd_tex,
  input  logic [8:0]                  cmd_x,
  input  logic [7:0]                  cmd_y,
  input  logic                        cmd_neg_x,
  input  logic                        cmd_neg_y,
  input  logic                        cmd_coords,
  output logic [3:0]                  master_address,
  output logic                        master_write,
  output logic [31:0]                 master_writedata,
  input  logic                        master_waitrequest,
  output logic                        busy,
  output logic                        plot_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  render_cmd_t      w_cmd_in;
  render_cmd_t      w_head;
  render_cmd_t      w_cur_nxt;
  render_cmd_t      r_cur;
  logic [CMD_W-1:0] w_head_bits;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_accept;
  render_state_t    r_state;
  render_state_t    w_state_nxt;
  logic             r_write;
  logic [3:0]       r_addr;
  logic [31:0]      r_data;
  logic             r_plot_done;

  assign w_cmd_in = '{tex: cmd_tex, x: cmd_x, y: cmd_y, neg_x: cmd_neg_x,
                      neg_y: cmd_neg_y, coords: cmd_coords};

  render_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (cmd_valid),
    .i_wdata (w_cmd_in),
    .i_pop   (w_pop),
    .o_rdata (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  assign w_head           = render_cmd_t'(w_head_bits);
  assign w_accept         = r_write && !master_waitrequest;
  assign cmd_ready        = !w_full;
  assign busy             = (r_state != ST_IDLE) || !w_empty;
  assign master_write     = r_write;
  assign master_address   = r_addr;
  assign master_writedata = r_data;
  assign plot_done        = r_plot_done;

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_cur_nxt   = w_head;
          w_state_nxt = ST_TEX;
        end
      end
      ST_PLOT: begin
        if (w_accept) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_cur_nxt   = w_head;
            w_state_nxt = ST_TEX;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        if (w_accept) w_state_nxt = next_write_state(r_state, r_cur);
      end
    endcase
  end

  // Bus outputs are registered from the next state, so a stalled write keeps
  // address/data constant simply because state and command do not change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cur       <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_plot_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur       <= w_cur_nxt;
      r_write     <= (w_state_nxt != ST_IDLE);
      r_addr      <= state_addr(w_state_nxt);
      r_data      <= state_data(w_state_nxt, w_cur_nxt);
      r_plot_done <= w_accept && (r_state == ST_PLOT);
    end
  end

endmodule

// File: doc/render_cmd_master.md
# render_cmd_master

Avalon-MM write master that drives the renderer's slave register port from a queue of draw commands. Upstream logic (game FSM or HPS bridge) pushes one command per sprite, background fill or line. The block expands each command into the renderer's register write sequence: texture code, negative-coordinate flag, X, Y, then plot trigger. It honours `waitrequest` throughout, including the long stall while a plot is in progress, so producers never have to sequence renderer registers themselves.

## Interface
- `FIFO_DEPTH`, default 8: command queue entries; power of two, ≥2.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  queue can accept; push occurs when `cmd_valid & cmd_ready` at the clock edge.
- `cmd_tex`  in  8  texture/colour code (written to renderer reg 4).
- `cmd_x`  in  9  X midpoint magnitude, 0..319.
- `cmd_y`  in  8  Y midpoint magnitude, 0..239.
- `cmd_neg_x`, `cmd_neg_y`  in  1  X or Y is negative.
- `cmd_coords`  in  1  0 = texture and plot only (background fill, multiplayer line).
- `master_address`  out  4  renderer register address.
- `master_write`  out  1  write request.
- `master_writedata`  out  32  write data.
- `master_waitrequest`  in  1  renderer stall.
- `busy`  out  1  FSM not IDLE or queue non-empty.
- `plot_done`  out  1  one-cycle pulse when a plot-trigger write is accepted.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  queued entries.

## Operation
- Queue: FIFO of packed commands (28 bits). `cmd_ready = !full`. A push while full is not accepted, even if a pop happens in the same cycle.
- Pop: the head is popped and latched into the command register `cur` when the FSM is in IDLE, or when a PLOT write is accepted, and the queue is non-empty.
- A write is accepted at a rising edge with `master_write=1` and `master_waitrequest=0`. While waitrequest is high, address, write and writedata stay constant.
- FSM states: IDLE, TEX, NEGX, X, NEGY, Y, NEGCLR, PLOT.
  - IDLE → TEX when the queue is non-empty (pop).
  - TEX (addr 4, data `{24'b0,tex}`) → NEGX if `coords`, else PLOT.
  - NEGX (addr 3, data `neg_x`) → X.
  - X (addr 1, data `{23'b0,x}`) → NEGY if `neg_y != neg_x`, else Y.
  - NEGY (addr 3, data `neg_y`) → Y.
  - Y (addr 2, data `{24'b0,y}`) → NEGCLR if `neg_y`, else PLOT.
  - NEGCLR (addr 3, data 0) → PLOT.
  - PLOT (addr 6, data 1) → TEX with a new pop if the queue is non-empty, else IDLE.
- Each state advances only on acceptance. NEGCLR guarantees the renderer's negative flag is 0 after every command.
- Outputs are registered. In IDLE: `master_write=0`, address and writedata 0.

## Timing
- Reset values: `master_write=0`, `master_address=0`, `master_writedata=0`, `plot_done=0`, `busy=0`, `fifo_level=0`, `cmd_ready=1`. FSM goes to IDLE and the queue is cleared.
- Latency: command pushed at edge N → head visible N+1 → popped at N+1 with `master_write=1` in TEX from N+2.
- With zero stall, each write state takes one cycle. A full-coordinate positive command takes 5 cycles (TEX, NEGX, X, Y, PLOT). Back-to-back commands have no IDLE gap.
- `plot_done` is high for the cycle following PLOT acceptance.
- Reset mid-transfer: `master_write` drops in the cycle after `rst`. This is permitted because the renderer shares the reset.
- `fifo_level` updates the cycle after a push or pop. A simultaneous push and pop leaves it unchanged.

## Structure
- Package `render_pkg`:
  - renderer register address constants (`REG_X=1`, `REG_Y=2`, `REG_NEG=3`, `REG_TEX=4`, `REG_PLOT=6`);
  - `render_cmd_t` packed struct {tex, x, y, neg_x, neg_y, coords};
  - FSM state enum.
- Sub-module `render_cmd_fifo`: synchronous FIFO parameterised by depth and width, with full, empty and level outputs.

## Test plan
- Background fill: tex 0xBC, coords=0 → writes (4,0xBC),(6,1). `plot_done` pulses once, then IDLE.
- Bird: tex 0x01, (20,20), no neg → (4,0x01),(3,0),(1,20),(2,20),(6,1) on 5 consecutive cycles.
- Pipe: tex 0x06, x=1, y=1, both neg → (4,6),(3,1),(1,1),(2,1),(3,0),(6,1).
- Mixed sign: x=5 neg, y=30 pos → (3,1),(1,5),(3,0),(2,30),(6,1). No NEGCLR write.
- Stall: hold waitrequest high for 3 cycles during X, and for 50 cycles after PLOT → outputs stay stable, no duplicate or skipped writes. With waitrequest held and FIFO_DEPTH 8, 9 commands are accepted and `cmd_ready` goes low on the 10th.
- Reset asserted mid-Y with 3 commands queued → next cycle `master_write=0`, `fifo_level=0`, `busy=0`. The next pushed command starts cleanly at TEX.
